// File: rtl/mem_pkg.sv
// Shared helpers for the RAM read-port controller and its response FIFO.
package mem_pkg;

  // Ceiling log2, usable in constant expressions (clog2(1) = 0).
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // The RAM wrapper only comes in combinational-read (1) or registered-output (2) flavours.
  function automatic bit read_latency_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/sync_fifo_reg.sv
// Register-based synchronous FIFO; head entry is read straight from the storage registers.
module sync_fifo_reg
  import mem_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int WIDTH_PTR = clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  output logic [WIDTH-1:0]     pop_data,
  output logic                 full,
  output logic                 empty,
  output logic [WIDTH_PTR-1:0] count
);

  localparam int WIDTH_IDX = clog2(DEPTH);
  localparam logic [WIDTH_PTR-1:0] PTR_ONE = WIDTH_PTR'(1);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [WIDTH_PTR-1:0] wr_ptr;
  logic [WIDTH_PTR-1:0] rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[WIDTH_PTR-1] != rd_ptr[WIDTH_PTR-1]) &&
                    (wr_ptr[WIDTH_IDX-1:0] == rd_ptr[WIDTH_IDX-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[WIDTH_IDX-1:0]];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Storage and pointer update; contents cleared on reset so the head reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[WIDTH_IDX-1:0]] <= push_data;
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // A push into a full FIFO means the upstream credit logic is broken.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full));
    end
  end

endmodule

// File: rtl/mem_rd_port_ctrl.sv
// Read-side controller for one port of the dual-port RAM wrapper: credit-limited request
// acceptance, fixed-latency read tracking and an in-order response FIFO.
module mem_rd_port_ctrl
  import mem_pkg::*;
#(
  parameter int WIDTH_DATA   = 8,
  parameter int WIDTH_ADDR   = 8,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int WIDTH_CNT    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [WIDTH_ADDR-1:0] req_addr,
  output logic [WIDTH_ADDR-1:0] ram_addr,
  output logic                  ram_ren,
  input  logic [WIDTH_DATA-1:0] ram_dout,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WIDTH_DATA-1:0] resp_data,
  output logic [WIDTH_CNT-1:0]  outstanding
);

  localparam logic [WIDTH_CNT-1:0] CNT_FULL = WIDTH_CNT'(FIFO_DEPTH);
  localparam logic [WIDTH_CNT-1:0] CNT_ONE  = WIDTH_CNT'(1);

  logic                    accept;
  logic                    pop;
  logic                    push;
  logic [READ_LATENCY-1:0] pipe_valid;
  logic [WIDTH_ADDR-1:0]   addr_q;
  logic [WIDTH_CNT-1:0]    cnt_q;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [WIDTH_CNT-1:0]    fifo_count;

  // Credits cover both in-flight reads and queued responses, so a granted read always
  // finds a free FIFO slot when its data returns.
  assign req_ready   = !rst && (cnt_q < CNT_FULL);
  assign accept      = req_valid && req_ready;
  assign ram_ren     = accept;
  assign ram_addr    = accept ? req_addr : addr_q;
  assign push        = pipe_valid[READ_LATENCY-1];
  assign resp_valid  = !fifo_empty;
  assign pop         = resp_valid && resp_ready;
  assign outstanding = cnt_q;

  // Latency pipeline, last accepted address and credit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      pipe_valid[0] <= accept;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
      end
      if (accept) begin
        addr_q <= req_addr;
      end
      if (accept && !pop) begin
        cnt_q <= cnt_q + CNT_ONE;
      end else if (pop && !accept) begin
        cnt_q <= cnt_q - CNT_ONE;
      end
    end
  end

  sync_fifo_reg #(
    .WIDTH (WIDTH_DATA),
    .DEPTH (FIFO_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (ram_dout),
    .pop       (pop),
    .pop_data  (resp_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Parameter legality and credit/FIFO consistency, simulation only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (read_latency_ok(READ_LATENCY));
      assert (WIDTH_CNT == clog2(FIFO_DEPTH) + 1);
      assert ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0);
      assert (FIFO_DEPTH >= READ_LATENCY + 1);
      assert (fifo_count <= cnt_q);
      assert (!fifo_full || (cnt_q == CNT_FULL));
    end
  end

endmodule

// File: tb/tb_mem_rd_port_ctrl.sv
// Bench for mem_rd_port_ctrl: one instance with READ_LATENCY=1 and one with READ_LATENCY=2,
// sharing request/response stimulus, each fed by its own RAM model.
module tb_mem_rd_port_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [7:0] req_addr = '0;
  logic       resp_ready = 1'b0;

  logic       req_ready_l1, ram_ren_l1, resp_valid_l1;
  logic [7:0] ram_addr_l1, resp_data_l1;
  logic [7:0] ram_dout_l1 = '0;
  logic [2:0] out_l1;

  logic       req_ready_l2, ram_ren_l2, resp_valid_l2;
  logic [7:0] ram_addr_l2, resp_data_l2;
  logic [7:0] ram_mid_l2 = '0;
  logic [7:0] ram_dout_l2 = '0;
  logic [2:0] out_l2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_rd_port_ctrl #(.WIDTH_DATA(8), .WIDTH_ADDR(8), .READ_LATENCY(1), .FIFO_DEPTH(4), .WIDTH_CNT(3)) dut_l1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_l1), .req_addr(req_addr),
    .ram_addr(ram_addr_l1), .ram_ren(ram_ren_l1), .ram_dout(ram_dout_l1),
    .resp_valid(resp_valid_l1), .resp_ready(resp_ready), .resp_data(resp_data_l1), .outstanding(out_l1));

  mem_rd_port_ctrl #(.WIDTH_DATA(8), .WIDTH_ADDR(8), .READ_LATENCY(2), .FIFO_DEPTH(4), .WIDTH_CNT(3)) dut_l2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_l2), .req_addr(req_addr),
    .ram_addr(ram_addr_l2), .ram_ren(ram_ren_l2), .ram_dout(ram_dout_l2),
    .resp_valid(resp_valid_l2), .resp_ready(resp_ready), .resp_data(resp_data_l2), .outstanding(out_l2));

  function automatic logic [7:0] ram_f(input logic [7:0] a);
    return (a == 8'h10) ? 8'hA5 : (a ^ 8'hFF);
  endfunction

  // RAM models: latency 1 (registered address) and latency 2 (extra output register).
  always @(posedge clk) begin
    if (ram_ren_l1) ram_dout_l1 <= ram_f(ram_addr_l1);
    if (ram_ren_l2) ram_mid_l2 <= ram_f(ram_addr_l2);
    ram_dout_l2 <= ram_mid_l2;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Holds reset for two edges with a request pending, checks reset values, then releases.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b1; req_addr = 8'h77; resp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready_l2, 0);
    chk("rst_ram_ren", ram_ren_l2, 0);
    chk("rst_ram_addr", ram_addr_l2, 0);
    chk("rst_resp_valid", resp_valid_l2, 0);
    chk("rst_resp_data", resp_data_l2, 0);
    chk("rst_outstanding", out_l2, 0);
    chk("rst_l1_resp_valid", resp_valid_l1, 0);
    chk("rst_l1_outstanding", out_l1, 0);
    rst = 1'b0; req_valid = 1'b0; req_addr = '0;
  endtask

  typedef struct {
    logic       rv;
    logic [7:0] addr;
    logic       rr;
    logic       e_rdy;
    logic       e_ren;
    logic [7:0] e_raddr;
    logic       e_valid;
    logic [7:0] e_data;
    logic [2:0] e_out;
  } vec_t;

  vec_t vecs[14];

  logic [7:0] q1[$];
  logic [7:0] q2[$];

  initial begin
    // Backpressure fill/drain on the latency-2 instance, with boundary addresses 0x00/0xFF.
    //          rv  addr   rr  rdy ren raddr  vld data   out
    vecs[0]  = '{1, 8'h20, 0,  1,  1,  8'h20, 0,  8'h00, 3'd0};
    vecs[1]  = '{1, 8'h21, 0,  1,  1,  8'h21, 0,  8'h00, 3'd1};
    vecs[2]  = '{1, 8'h22, 0,  1,  1,  8'h22, 0,  8'h00, 3'd2};
    vecs[3]  = '{1, 8'h23, 0,  1,  1,  8'h23, 1,  8'hDF, 3'd3};
    vecs[4]  = '{1, 8'h24, 0,  0,  0,  8'h23, 1,  8'hDF, 3'd4};
    vecs[5]  = '{1, 8'h25, 0,  0,  0,  8'h23, 1,  8'hDF, 3'd4};
    vecs[6]  = '{0, 8'h00, 1,  0,  0,  8'h23, 1,  8'hDF, 3'd4};
    vecs[7]  = '{0, 8'h00, 1,  1,  0,  8'h23, 1,  8'hDE, 3'd3};
    vecs[8]  = '{1, 8'h00, 1,  1,  1,  8'h00, 1,  8'hDD, 3'd2};
    vecs[9]  = '{1, 8'hFF, 1,  1,  1,  8'hFF, 1,  8'hDC, 3'd2};
    vecs[10] = '{0, 8'h00, 1,  1,  0,  8'hFF, 0,  8'h00, 3'd2};
    vecs[11] = '{0, 8'h00, 1,  1,  0,  8'hFF, 1,  8'hFF, 3'd2};
    vecs[12] = '{0, 8'h00, 1,  1,  0,  8'hFF, 1,  8'h00, 3'd1};
    vecs[13] = '{0, 8'h00, 0,  1,  0,  8'hFF, 0,  8'h00, 3'd0};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      req_valid = vecs[i].rv; req_addr = vecs[i].addr; resp_ready = vecs[i].rr;
      #1;
      chk($sformatf("vec%0d_req_ready", i), req_ready_l2, vecs[i].e_rdy);
      chk($sformatf("vec%0d_ram_ren", i), ram_ren_l2, vecs[i].e_ren);
      chk($sformatf("vec%0d_ram_addr", i), ram_addr_l2, vecs[i].e_raddr);
      chk($sformatf("vec%0d_resp_valid", i), resp_valid_l2, vecs[i].e_valid);
      if (vecs[i].e_valid) chk($sformatf("vec%0d_resp_data", i), resp_data_l2, vecs[i].e_data);
      chk($sformatf("vec%0d_outstanding", i), out_l2, vecs[i].e_out);
      @(negedge clk);
    end

    // Single read on the latency-1 instance: request at cycle 5, response at cycle 7.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      req_valid = (k == 5); req_addr = 8'h10; resp_ready = 1'b1;
      #1;
      if (k == 5) begin
        chk("single_ram_ren", ram_ren_l1, 1);
        chk("single_ram_addr", ram_addr_l1, 8'h10);
      end
      if (k == 6) chk("single_early_valid", resp_valid_l1, 0);
      if (k == 7) begin
        chk("single_resp_valid", resp_valid_l1, 1);
        chk("single_resp_data", resp_data_l1, 8'hA5);
      end
      @(negedge clk);
    end

    // Streaming 16 back-to-back reads on the latency-2 instance.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      req_valid = (k < 16); req_addr = 8'(k); resp_ready = 1'b1;
      #1;
      chk($sformatf("stream%0d_req_ready", k), req_ready_l2, 1);
      chk($sformatf("stream%0d_resp_valid", k), resp_valid_l2, (k >= 3) && (k < 19));
      if ((k >= 3) && (k < 19)) chk($sformatf("stream%0d_resp_data", k), resp_data_l2, 8'(k - 3) ^ 8'hFF);
      @(negedge clk);
    end

    // Reset while two reads are in flight and one response is queued.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1; req_addr = 8'h30 + 8'(k); resp_ready = 1'b0;
      @(negedge clk);
    end
    req_valid = 1'b0;
    #1;
    chk("midrst_pre_valid", resp_valid_l2, 1);
    chk("midrst_pre_data", resp_data_l2, 8'hCF);
    chk("midrst_pre_out", out_l2, 3);
    rst = 1'b1;
    #1;
    chk("midrst_req_ready_low", req_ready_l2, 0);
    @(negedge clk);
    rst = 1'b0; resp_ready = 1'b1;
    #1;
    chk("midrst_post_valid", resp_valid_l2, 0);
    chk("midrst_post_out", out_l2, 0);
    chk("midrst_post_ready", req_ready_l2, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      req_valid = (k == 3); req_addr = 8'h55;
      #1;
      if (k < 6) chk($sformatf("midrst_stale%0d", k), resp_valid_l2, 0);
      if (k == 6) begin
        chk("midrst_new_valid", resp_valid_l2, 1);
        chk("midrst_new_data", resp_data_l2, 8'hAA);
      end
    end
    @(negedge clk);

    // Random reads with random backpressure; scoreboards and counter models for both instances.
    do_reset();
    begin
      int issued = 0;
      int cyc = 0;
      int exp_o1 = 0;
      int exp_o2 = 0;
      logic acc1, acc2, pop1, pop2;
      while ((issued < 100 || out_l1 != 0 || out_l2 != 0) && cyc < 4000) begin
        req_valid = (issued < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
        req_addr = 8'($urandom_range(0, 255));
        resp_ready = ($urandom_range(0, 3) != 0);
        #1;
        chk("rand_out_l1", out_l1, exp_o1);
        chk("rand_out_l2", out_l2, exp_o2);
        acc1 = req_valid && req_ready_l1;
        acc2 = req_valid && req_ready_l2;
        pop1 = resp_valid_l1 && resp_ready;
        pop2 = resp_valid_l2 && resp_ready;
        if (pop1) begin
          if (q1.size() == 0) chk("rand_spurious_l1", 1, 0);
          else chk("rand_data_l1", resp_data_l1, q1.pop_front());
        end
        if (pop2) begin
          if (q2.size() == 0) chk("rand_spurious_l2", 1, 0);
          else chk("rand_data_l2", resp_data_l2, q2.pop_front());
        end
        if (acc1) q1.push_back(ram_f(req_addr));
        if (acc2) begin
          q2.push_back(ram_f(req_addr));
          issued++;
        end
        exp_o1 = exp_o1 + int'(acc1) - int'(pop1);
        exp_o2 = exp_o2 + int'(acc2) - int'(pop2);
        cyc++;
        @(negedge clk);
      end
      chk("rand_issued", issued, 100);
      chk("rand_q1_drained", q1.size(), 0);
      chk("rand_q2_drained", q2.size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
